// File: rtl/firebird7_in_gate1_hdspsr_trim_apply_seq.sv
// firebird7_in_gate1_hdspsr_trim_apply_seq: merges TDR override and fuse trim, then applies changes to the
// hdspsr array behind a hold/setup/apply/hold handshake so trim never moves under an active access.
module firebird7_in_gate1_hdspsr_trim_apply_seq #(
  parameter int                 TRIM_W       = 19,
  parameter logic [TRIM_W-1:0]  SAFE_TRIM    = '0,
  parameter int                 SETUP_CYC    = 2,
  parameter int                 HOLD_CYC     = 2,
  parameter int                 IDLE_TIMEOUT = 64,
  parameter int                 CNT_W        = 8
) (
  input  logic              ijtag_tck,
  input  logic              ijtag_reset,
  input  logic              ovrd_en,
  input  logic [TRIM_W-1:0] ovrd_trim,
  input  logic [TRIM_W-1:0] fuse_trim,
  input  logic              fuse_valid,
  input  logic              array_idle,
  output logic              trim_hold,
  output logic [TRIM_W-1:0] trim_out,
  output logic              trim_src,
  output logic              trim_busy,
  output logic              trim_update_done,
  output logic              timeout_err,
  output logic [CNT_W-1:0]  apply_count
);
  localparam int TMO_W = IDLE_TIMEOUT > 1 ? $clog2(IDLE_TIMEOUT) : 1;
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(IDLE_TIMEOUT == 0 ? 0 : IDLE_TIMEOUT - 1);
  typedef enum logic [2:0] {IDLE, WAIT_IDLE, SETUP, APPLY, HOLD} state_t;
  state_t            state_q, state_d;
  logic              ovrd_en_q, fuse_valid_q;
  logic [TRIM_W-1:0] ovrd_trim_q, fuse_trim_q;
  logic [TRIM_W-1:0] pend_q, pend_d, trim_out_q, trim_out_d, target;
  logic              pend_src_q, pend_src_d, trim_src_q, trim_src_d, tgt_src;
  logic              hold_q, hold_d, busy_q, busy_d, done_q, done_d, err_q, err_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [TMO_W-1:0]  tmo_q, tmo_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              tmo_hit;
  assign target  = ovrd_en_q ? ovrd_trim_q : fuse_valid_q ? fuse_trim_q : SAFE_TRIM;
  assign tgt_src = ovrd_en_q;
  assign tmo_hit = (IDLE_TIMEOUT != 0) && (tmo_q == TMO_LAST);
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    tmo_d      = tmo_q;
    pend_d     = pend_q;
    pend_src_d = pend_src_q;
    trim_out_d = trim_out_q;
    trim_src_d = trim_src_q;
    hold_d     = hold_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    err_d      = err_q;
    count_d    = count_q;
    case (state_q)
      IDLE:
        if ({tgt_src, target} != {trim_src_q, trim_out_q}) begin
          state_d    = WAIT_IDLE;
          pend_d     = target;
          pend_src_d = tgt_src;
          busy_d     = 1'b1;
          tmo_d      = '0;
        end
      WAIT_IDLE:
        if (array_idle || tmo_hit) begin
          state_d = SETUP;
          hold_d  = 1'b1;
          cnt_d   = 4'(SETUP_CYC);
          err_d   = err_q | ~array_idle;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      SETUP:
        if (cnt_q == 4'd1) state_d = APPLY;
        else cnt_d = cnt_q - 1'b1;
      APPLY: begin
        trim_out_d = pend_q;
        trim_src_d = pend_src_q;
        cnt_d      = 4'(HOLD_CYC);
        state_d    = HOLD;
      end
      HOLD:
        if (cnt_q == 4'd1) begin
          state_d = IDLE;
          hold_d  = 1'b0;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          count_d = &count_q ? count_q : count_q + 1'b1;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge ijtag_tck or negedge ijtag_reset) begin
    if (!ijtag_reset) begin
      ovrd_en_q    <= 1'b0;
      ovrd_trim_q  <= '0;
      fuse_trim_q  <= '0;
      fuse_valid_q <= 1'b0;
      state_q      <= IDLE;
      cnt_q        <= '0;
      tmo_q        <= '0;
      pend_q       <= SAFE_TRIM;
      pend_src_q   <= 1'b0;
      trim_out_q   <= SAFE_TRIM;
      trim_src_q   <= 1'b0;
      hold_q       <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
      count_q      <= '0;
    end else begin
      ovrd_en_q    <= ovrd_en;
      ovrd_trim_q  <= ovrd_trim;
      fuse_trim_q  <= fuse_trim;
      fuse_valid_q <= fuse_valid;
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      tmo_q        <= tmo_d;
      pend_q       <= pend_d;
      pend_src_q   <= pend_src_d;
      trim_out_q   <= trim_out_d;
      trim_src_q   <= trim_src_d;
      hold_q       <= hold_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      err_q        <= err_d;
      count_q      <= count_d;
    end
  end
  assign trim_hold        = hold_q;
  assign trim_out         = trim_out_q;
  assign trim_src         = trim_src_q;
  assign trim_busy        = busy_q;
  assign trim_update_done = done_q;
  assign timeout_err      = err_q;
  assign apply_count      = count_q;
endmodule

// File: tb/tb_firebird7_in_gate1_hdspsr_trim_apply_seq.sv
// tb_firebird7_in_gate1_hdspsr_trim_apply_seq: scoreboard bench; expected applies are queued at stimulus
// time and popped by a monitor on every done pulse.
module tb_firebird7_in_gate1_hdspsr_trim_apply_seq;
  localparam int TW = 19;
  logic          clk = 1'b0, rst_n = 1'b0;
  logic          ovrd_en = 1'b0, fuse_valid = 1'b0, array_idle = 1'b1;
  logic [TW-1:0] ovrd_trim = '0, fuse_trim = '0;
  logic          hold, src, busy, done, err;
  logic [TW-1:0] trim_out;
  logic [7:0]    apply_count;
  int            total = 0, bad = 0, done_seen = 0, exp_cnt = 0;
  logic [TW:0]   q[$];
  logic [TW:0]   app = '0;
  logic [TW-1:0] prev_out = '0;
  logic          prev_rst = 1'b0;

  firebird7_in_gate1_hdspsr_trim_apply_seq dut (
    .ijtag_tck(clk), .ijtag_reset(rst_n), .ovrd_en(ovrd_en), .ovrd_trim(ovrd_trim),
    .fuse_trim(fuse_trim), .fuse_valid(fuse_valid), .array_idle(array_idle),
    .trim_hold(hold), .trim_out(trim_out), .trim_src(src), .trim_busy(busy),
    .trim_update_done(done), .timeout_err(err), .apply_count(apply_count));

  always #5 clk = ~clk;

  task automatic check(input string n, input logic [31:0] a, input logic [31:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s actual=%h expected=%h t=%0t", n, a, e, $time);
    end
  endtask

  // Effective trim the array should end up with, from the inputs as driven.
  function automatic logic [TW:0] want();
    if (ovrd_en) return {1'b1, ovrd_trim};
    if (fuse_valid) return {1'b0, fuse_trim};
    return '0;
  endfunction

  task automatic issue();
    if (want() != app) begin
      app = want();
      q.push_back(app);
    end
  endtask

  task automatic wait_quiet();
    int i;
    repeat (3) @(negedge clk);
    for (i = 0; i < 400 && (busy || q.size() != 0); i++) @(negedge clk);
    check("settle", {31'd0, busy || q.size() != 0}, 0);
  endtask

  always @(negedge clk) begin
    if (rst_n && prev_rst && trim_out !== prev_out) check("out_moved_only_under_hold", {31'd0, hold}, 1);
    prev_out = trim_out;
    prev_rst = rst_n;
    if (rst_n && done) begin
      done_seen++;
      if (q.size() == 0) check("done_without_expected", 0, 1);
      else begin
        logic [TW:0] e;
        e = q.pop_front();
        exp_cnt = exp_cnt < 255 ? exp_cnt + 1 : 255;
        check("trim_out", {13'd0, trim_out}, {13'd0, e[TW-1:0]});
        check("trim_src", {31'd0, src}, {31'd0, e[TW]});
        check("apply_count", {24'd0, apply_count}, exp_cnt);
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

  initial begin
    int hf, of, dn, hc, d0, i;
    repeat (3) @(negedge clk);
    check("rst_out", {13'd0, trim_out}, 0);
    check("rst_hold", {31'd0, hold}, 0);
    check("rst_busy", {31'd0, busy}, 0);
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
    check("idle_out", {13'd0, trim_out}, 0);
    check("idle_busy", {31'd0, busy}, 0);
    check("idle_count", {24'd0, apply_count}, 0);
    check("idle_err", {31'd0, err}, 0);
    // fuse load with latency measurement
    fuse_trim = 19'h2A5F3; fuse_valid = 1'b1; issue();
    hf = 0; of = 0; dn = 0; hc = 0;
    for (i = 1; i <= 12; i++) begin
      @(negedge clk);
      if (hold && hf == 0) hf = i;
      if (trim_out == 19'h2A5F3 && of == 0) of = i;
      if (done && dn == 0) dn = i;
      hc += int'(hold);
    end
    check("hold_rise", hf, 3);
    check("out_update", of, 6);
    check("done_at", dn, 8);
    check("hold_len", hc, 5);
    wait_quiet();
    ovrd_trim = 19'h7FFFF; ovrd_en = 1'b1; issue(); wait_quiet();
    ovrd_en = 1'b0; issue(); wait_quiet();
    check("count3", {24'd0, apply_count}, 3);
    // array never idle: timeout path
    array_idle = 1'b0; ovrd_trim = 19'h12345; ovrd_en = 1'b1; issue();
    hf = 0;
    for (i = 1; i <= 80 && hf == 0; i++) begin
      @(negedge clk);
      if (hold) hf = i;
    end
    check("timeout_hold_rise", hf, 66);
    check("timeout_err", {31'd0, err}, 1);
    array_idle = 1'b1; wait_quiet();
    // target changes twice during SETUP
    d0 = done_seen;
    ovrd_trim = 19'h11111; issue();
    for (i = 0; i < 20 && !hold; i++) @(negedge clk);
    check("mid_setup_reached", {31'd0, hold}, 1);
    ovrd_trim = 19'h22222;
    @(negedge clk);
    ovrd_trim = 19'h33333; issue();
    wait_quiet();
    check("mid_two_dones", done_seen - d0, 2);
    // randomized traffic
    for (int n = 0; n < 25; n++) begin
      if ($urandom_range(0, 3) != 0) begin
        ovrd_en = $urandom_range(0, 2) == 0;
        ovrd_trim = TW'($urandom);
        fuse_valid = $urandom_range(0, 3) != 0;
        fuse_trim = TW'($urandom);
      end
      array_idle = $urandom_range(0, 3) != 0;
      issue();
      wait_quiet();
    end
    check("err_sticky", {31'd0, err}, 1);
    // reset during HOLD
    array_idle = 1'b1; ovrd_en = 1'b1; ovrd_trim = 19'h5A5A5; issue(); wait_quiet();
    ovrd_trim = 19'h7FFFF; issue();
    for (i = 0; i < 30 && !(hold && trim_out == 19'h7FFFF); i++) @(negedge clk);
    check("in_hold_before_rst", {31'd0, hold && trim_out == 19'h7FFFF}, 1);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_out", {13'd0, trim_out}, 0);
    check("async_rst_hold", {31'd0, hold}, 0);
    check("async_rst_src", {31'd0, src}, 0);
    q.delete(); app = '0; exp_cnt = 0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1; issue();
    wait_quiet();
    check("post_rst_out", {13'd0, trim_out}, 19'h7FFFF);
    check("post_rst_count", {24'd0, apply_count}, 1);
    check("post_rst_err", {31'd0, err}, 0);
    check("sb_empty", q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
